// File: rtl/sram_req_pkg.sv
`default_nettype none
// ============================================================================
// Package : sram_req_pkg
// Shared types and parameter helpers for the SRAM request port.
// Revision: 1.0  initial release
// ============================================================================
package sram_req_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        INIT = 1'b1
    } state_e;

    localparam int BYTE_W = 8;

    function automatic int be_width(input int data_w);
        return data_w / BYTE_W;
    endfunction

    function automatic bit params_ok(input int data_w, input int depth,
                                     input int read_lat, input int rsp_depth);
        return (data_w > 0) && (data_w % BYTE_W == 0) && (depth >= 2) &&
               (read_lat >= 1) && (read_lat <= 4) && (rsp_depth >= read_lat + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_array_model.sv
`default_nettype none
// ============================================================================
// Module  : sram_array_model
// Behavioural word array: byte-masked write, one-cycle registered read.
// Revision: 1.0  initial release
// ============================================================================
module sram_array_model
    import sram_req_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int BE_W   = be_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;

    assign in_range = ({1'b0, addr} < DEPTH_L);

    // Contents are deliberately not reset; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (we && in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= in_range ? mem[addr] : '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_req_port.sv
`default_nettype none
// ============================================================================
// Module  : sram_req_port
// Valid/ready SRAM port with read pipeline, response FIFO and zero-init sweep.
// Revision: 1.0  initial release
// ============================================================================
module sram_req_port
    import sram_req_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 128,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int READ_LAT  = 2,
    parameter int RSP_DEPTH = READ_LAT + 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    input  logic                  init_start,
    output logic                  init_busy,
    output logic                  init_done,
    output logic                  oob_err
);

    localparam int BE_W  = be_width(DATA_W);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(RSP_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);

    if (!params_ok(DATA_W, DEPTH, READ_LAT, RSP_DEPTH)) begin : g_param_check
        $error("sram_req_port: illegal DATA_W/DEPTH/READ_LAT/RSP_DEPTH combination");
    end

    state_e              state, state_nxt;
    logic [ADDR_W-1:0]   init_addr;
    logic [CNT_W-1:0]    outstanding;
    logic                req_fire, rd_fire, wr_fire, rsp_fire;
    logic                arr_we;
    logic [ADDR_W-1:0]   arr_addr;
    logic [DATA_W-1:0]   arr_wdata, arr_rdata, last_d;
    logic [BE_W-1:0]     arr_be;
    logic [READ_LAT:1]   vld;
    logic                last_v;
    logic [DATA_W-1:0]   fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    fifo_cnt;
    logic                fifo_empty, push, pop_fifo;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (init_start) state_nxt = INIT;
            INIT:    if (init_addr == ADDR_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        init_busy = (state == INIT);
        req_ready = (state == IDLE) && !init_start && (outstanding < CNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_addr <= '0;
            init_done <= 1'b0;
            oob_err   <= 1'b0;
        end else begin
            init_done <= (state == INIT) && (init_addr == ADDR_LAST);
            oob_err   <= req_fire && ({1'b0, req_addr} >= DEPTH_L);
            if ((state == INIT) && (init_addr != ADDR_LAST)) init_addr <= init_addr + ADDR_W'(1);
            else                                             init_addr <= '0;
        end
    end

    // ---------------- Request side ----------------
    assign req_fire  = req_valid && req_ready;
    assign rd_fire   = req_fire && !req_we;
    assign wr_fire   = req_fire && req_we;
    assign arr_we    = init_busy || wr_fire;
    assign arr_addr  = init_busy ? init_addr : req_addr;
    assign arr_wdata = init_busy ? '0 : req_wdata;
    assign arr_be    = init_busy ? '1 : req_be;

    sram_array_model #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .BE_W   (BE_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .re    (rd_fire),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .be    (arr_be),
        .rdata (arr_rdata)
    );

    // ---------------- Read pipeline ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld <= '0;
        else     vld <= (vld << 1) | READ_LAT'(rd_fire);
    end
    assign last_v = vld[READ_LAT];

    if (READ_LAT == 1) begin : g_lat_direct
        assign last_d = arr_rdata;
    end else begin : g_lat_pipe
        logic [DATA_W-1:0] pipe_d [2:READ_LAT];
        always_ff @(posedge clk) begin
            pipe_d[2] <= arr_rdata;
            for (int i = 3; i <= READ_LAT; i++) pipe_d[i] <= pipe_d[i-1];
        end
        assign last_d = pipe_d[READ_LAT];
    end

    // ---------------- Response FIFO ----------------
    // The final pipeline stage is presented directly when the FIFO is empty;
    // if it is not taken that cycle it lands in the FIFO with identical data.
    assign fifo_empty = (fifo_cnt == '0);
    assign rsp_valid  = !fifo_empty || last_v;
    assign pop_fifo   = !fifo_empty && rsp_ready;
    assign push       = last_v && !(fifo_empty && rsp_ready);
    assign rsp_fire   = rsp_valid && rsp_ready;
    assign rsp_rdata  = !rsp_valid ? '0 : (fifo_empty ? last_d : fifo_mem[rd_ptr]);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= last_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            outstanding <= '0;
        end else begin
            if (push)     wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            if (pop_fifo) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            case ({push, pop_fifo})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            case ({rd_fire, rsp_fire})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop_fifo && (fifo_cnt == CNT_MAX)))
        else $error("sram_req_port: push into full response FIFO");

endmodule
`default_nettype wire

// File: tb/tb_sram_req_port.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_req_port
// Self-checking bench: reference memory + expected-response queue.
// Revision: 1.0  initial release
// ============================================================================
module tb_sram_req_port;

    localparam int DW = 16;
    localparam int AW = 7;
    localparam int DEPTH_A = 128;
    localparam int DEPTH_B = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, req_valid, req_ready, req_we, rsp_valid, rsp_ready;
    logic          init_start, init_busy, init_done, oob_err;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata, rsp_rdata;
    logic [1:0]    req_be;

    logic          b_rst, b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
    logic          b_init_start, b_init_busy, b_init_done, b_oob_err;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_wdata, b_rsp_rdata;
    logic [1:0]    b_req_be;

    sram_req_port #(.DATA_W(DW), .DEPTH(DEPTH_A), .READ_LAT(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
        .oob_err(oob_err));

    sram_req_port #(.DATA_W(DW), .DEPTH(DEPTH_B), .READ_LAT(2)) dut_b (
        .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .init_start(b_init_start), .init_busy(b_init_busy), .init_done(b_init_done),
        .oob_err(b_oob_err));

    int checks = 0;
    int failures = 0;
    int n_rd = 0;
    int n_rsp = 0;
    logic [DW-1:0] mem_m [DEPTH_A];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_rsp = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle seen from the negedge: score handshakes, then advance.
    task automatic tick();
        if (rsp_valid && rsp_ready) begin
            n_rsp++;
            last_rsp = rsp_rdata;
            if (exp_q.size() == 0) chk("rsp_extra", 32'(n_rsp), 32'(n_rd));
            else                   chk("rsp_data", 32'(rsp_rdata), 32'(exp_q.pop_front()));
        end
        if (req_valid && req_ready) begin
            if (req_we) begin
                for (int i = 0; i < 2; i++)
                    if (req_be[i]) mem_m[req_addr][8*i +: 8] = req_wdata[8*i +: 8];
            end else begin
                exp_q.push_back(mem_m[req_addr]);
                n_rd++;
            end
        end
        if (init_start && !init_busy)
            for (int a = 0; a < DEPTH_A; a++) mem_m[a] = '0;
        @(negedge clk);
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick();
        chk("drain_left", 32'(exp_q.size()), 0);
    endtask

    task automatic do_req(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [1:0] be);
        bit done = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; req_be = be;
        for (int i = 0; i < 50 && !done; i++) begin
            done = req_ready;
            tick();
        end
        req_valid = 1'b0;
        chk("req_accept", 32'(done), 1);
    endtask

    task automatic b_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bit done = 1'b0;
        b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = data; b_req_be = 2'b11;
        for (int i = 0; i < 20 && !done; i++) begin
            done = b_req_ready;
            @(negedge clk);
        end
        b_req_valid = 1'b0;
        chk("b_req_accept", 32'(done), 1);
    endtask

    task automatic b_wait_rsp(input string tag, input logic [DW-1:0] exp);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (b_rsp_valid && b_rsp_ready) begin
                got = 1'b1;
                chk(tag, 32'(b_rsp_rdata), 32'(exp));
            end
            @(negedge clk);
        end
        chk({tag, "_seen"}, 32'(got), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, busy, dn, bad;
        bit a, flag;
        logic [AW-1:0] t5_addr [3];
        t5_addr = '{7'd0, 7'd64, 7'd127};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_be = '0; rsp_ready = 1'b0; init_start = 1'b0;
        b_rst = 1'b1; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        b_req_be = '0; b_rsp_ready = 1'b0; b_init_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_init_busy", 32'(init_busy), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_oob_err",   32'(oob_err), 0);
        rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 1);

        // Test 1: write then read with latency check
        rsp_ready = 1'b1;
        do_req(1'b1, 7'd5, 16'hBEEF, 2'b11);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 7'd5;
        chk("t1_ready", 32'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        chk("t1_valid_lat1", 32'(rsp_valid), 0);
        tick();
        chk("t1_valid_lat2", 32'(rsp_valid), 1);
        chk("t1_rdata", 32'(rsp_rdata), 32'hBEEF);
        drain();

        // Test 2: byte mask
        do_req(1'b1, 7'd9, 16'h1234, 2'b11);
        do_req(1'b1, 7'd9, 16'hAB00, 2'b10);
        do_req(1'b0, 7'd9, 16'h0000, 2'b00);
        drain();
        chk("t2_bytemask", 32'(last_rsp), 32'hAB34);

        // Fill array, then some random partial writes
        for (int i = 0; i < DEPTH_A; i++) do_req(1'b1, AW'(i), DW'($urandom), 2'b11);
        for (int i = 0; i < 20; i++)
            do_req(1'b1, AW'($urandom_range(0, DEPTH_A-1)), DW'($urandom), 2'($urandom_range(0, 3)));

        // Test 3: backpressure
        rsp_ready = 1'b0;
        n0 = n_rd;
        req_valid = 1'b1; req_we = 1'b0; req_addr = AW'($urandom_range(0, DEPTH_A-1));
        for (int i = 0; i < 12; i++) begin
            a = req_ready;
            tick();
            if (a) req_addr = AW'($urandom_range(0, DEPTH_A-1));
        end
        req_valid = 1'b0;
        chk("t3_accepted", 32'(n_rd - n0), 4);
        chk("t3_ready_low", 32'(req_ready), 0);
        chk("t3_head_valid", 32'(rsp_valid), 1);
        chk("t3_head_data", 32'(rsp_rdata), 32'(exp_q[0]));
        n1 = n_rsp;
        drain();
        chk("t3_responses", 32'(n_rsp - n1), 4);

        // Test 4: streaming
        rsp_ready = 1'b1;
        n0 = n_rd; n1 = n_rsp; flag = 1'b0;
        req_valid = 1'b1; req_we = 1'b0;
        for (int i = 0; i < 50; i++) begin
            req_addr = AW'($urandom_range(0, DEPTH_A-1));
            if (!req_ready) flag = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        chk("t4_ready_held", 32'(flag), 0);
        drain();
        chk("t4_accepted", 32'(n_rd - n0), 50);
        chk("t4_responses", 32'(n_rsp - n1), 50);

        // Random mixed traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom_range(0, DEPTH_A-1));
            req_wdata = DW'($urandom);
            req_be    = 2'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = 1'b0;
        drain();

        // Test 5: init sweep with a read still in flight
        do_req(1'b1, 7'd127, 16'hC0DE, 2'b11);
        do_req(1'b0, 7'd127, 16'h0000, 2'b00);
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        busy = 0; dn = 0; bad = 0;
        for (int i = 0; i < 140; i++) begin
            if (init_busy) busy++;
            if (init_done) dn++;
            if (init_busy && req_ready) bad++;
            tick();
        end
        chk("t5_busy_cycles", 32'(busy), 128);
        chk("t5_done_pulses", 32'(dn), 1);
        chk("t5_ready_in_init", 32'(bad), 0);
        chk("t5_inflight_old", 32'(last_rsp), 32'hC0DE);
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, t5_addr[i], 16'h0000, 2'b00);
            drain();
            chk("t5_zero", 32'(last_rsp), 0);
        end

        // Test 6: DEPTH=100 instance
        b_rsp_ready = 1'b1;
        b_req(1'b1, 7'd50, 16'h5A5A);
        chk("t6_inrange_no_oob", 32'(b_oob_err), 0);
        b_req(1'b1, 7'd105, 16'hFFFF);
        chk("t6_oob_write", 32'(b_oob_err), 1);
        b_req(1'b0, 7'd110, 16'h0000);
        chk("t6_oob_read", 32'(b_oob_err), 1);
        @(negedge clk);
        chk("t6_oob_clear", 32'(b_oob_err), 0);
        b_wait_rsp("t6_oob_rdata", 16'h0000);

        b_rsp_ready = 1'b0;
        b_req(1'b0, 7'd50, 16'h0000);
        b_req(1'b0, 7'd50, 16'h0000);
        @(negedge clk);
        chk("t6_pre_reset_valid", 32'(b_rsp_valid), 1);
        b_rst = 1'b1;
        #1;
        chk("t6_reset_async", 32'(b_rsp_valid), 0);
        @(negedge clk);
        b_rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_discarded", 32'(b_rsp_valid), 0);
        b_rsp_ready = 1'b1;
        b_req(1'b0, 7'd50, 16'h0000);
        b_wait_rsp("t6_persist", 16'h5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
